ring_osc_trng: RTL and testbench

//  Parametrised ring-oscillator entropy source. NUM_RINGS free-running rings of sg13g2 cells are

---
 rtl/ring_osc_trng.sv | 214 +++++++++++++++++++++
 tb/tb_ring_osc_trng.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ring_osc_trng.sv
// Functional models of the two sg13g2 ring cells; the PDK library provides the real ones.
module sg13g2_nand2_1 (
    input  logic A,
    input  logic B,
    output logic Y
);
    assign Y = ~(A & B);
endmodule

module sg13g2_inv_2 (
    input  logic A,
    output logic Y
);
    assign Y = ~A;
endmodule

// Ring-oscillator TRNG: XOR of synchronised rings sampled every DIV clocks, optional von Neumann, packed to words.
// Last emitted bit -> out_valid in 1 clk; a full holding register stalls the shift register and drops later bits.
module ring_osc_trng #(
    parameter int NUM_RINGS = 4,
    parameter int STAGES    = 5,
    parameter int DIV       = 8,
    parameter int WORD_W    = 8,
    parameter int DEBIAS    = 1,
    parameter int REP_LIMIT = 16,
    parameter int SIM_RINGS = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              test_mode,
    input  logic              test_bit,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              raw_bit,
    output logic              stuck
);
    localparam int DIV_W  = $clog2(DIV + 1);
    localparam int BCNT_W = $clog2(WORD_W + 1);
    localparam int REP_W  = $clog2(REP_LIMIT + 1);

    logic [NUM_RINGS-1:0] w_ring;
    logic [NUM_RINGS-1:0] r_sync1;
    logic [NUM_RINGS-1:0] r_sync2;
    logic                 w_comb;
    logic [DIV_W-1:0]     r_div_cnt;
    logic                 w_strobe;
    logic                 w_sample;
    logic                 r_raw_bit;
    logic [REP_W-1:0]     r_rep;
    logic [REP_W-1:0]     w_rep_next;
    logic                 r_stuck;
    logic                 w_emit;
    logic                 w_emit_bit;
    logic [WORD_W-1:0]    r_shreg;
    logic [BCNT_W-1:0]    r_bcnt;
    logic [WORD_W-1:0]    r_out_data;
    logic                 r_out_valid;
    logic                 w_full;
    logic                 w_hold_free;
    logic                 w_xfer;
    logic                 w_shift;

    // SIM_RINGS=1 swaps each ring for a clocked square wave so cycle-based simulators can run with ena=1.
    for (genvar gi = 0; gi < NUM_RINGS; gi++) begin : g_ring
        if (SIM_RINGS != 0) begin : g_model
            localparam int HP = STAGES + 2 * gi;
            logic [7:0] r_cnt;
            logic       r_osc;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                    r_osc <= 1'b0;
                end else if (ena) begin
                    if (r_cnt == 8'(HP - 1)) begin
                        r_cnt <= '0;
                        r_osc <= ~r_osc;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
            end

            assign w_ring[gi] = r_osc;
        end else begin : g_cells
            (* keep, dont_touch *) logic [STAGES-1:0] w_net;

            (* keep, dont_touch *)
            sg13g2_nand2_1 u_nand (
                .A (ena),
                .B (w_net[STAGES-1]),
                .Y (w_net[0])
            );

            for (genvar gk = 1; gk < STAGES; gk++) begin : g_inv
                (* keep, dont_touch *)
                sg13g2_inv_2 u_inv (
                    .A (w_net[gk-1]),
                    .Y (w_net[gk])
                );
            end

            assign w_ring[gi] = w_net[STAGES-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_ring;
            r_sync2 <= r_sync1;
        end
    end

    assign w_comb   = ^r_sync2;
    assign w_strobe = ena && (r_div_cnt == DIV_W'(DIV - 1));
    assign w_sample = test_mode ? test_bit : w_comb;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
        end else if (ena) begin
            r_div_cnt <= w_strobe ? '0 : r_div_cnt + DIV_W'(1);
        end
    end

    // A fresh run restarts at 1; from reset r_rep=0 so the first sample also lands on 1.
    always_comb begin
        w_rep_next = REP_W'(1);
        if (w_sample == r_raw_bit) begin
            w_rep_next = (r_rep == REP_W'(REP_LIMIT)) ? r_rep : r_rep + REP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_raw_bit <= 1'b0;
            r_rep     <= '0;
            r_stuck   <= 1'b0;
        end else if (w_strobe) begin
            r_raw_bit <= w_sample;
            r_rep     <= w_rep_next;
            if (w_rep_next == REP_W'(REP_LIMIT)) begin
                r_stuck <= 1'b1;
            end
        end
    end

    if (DEBIAS != 0) begin : g_vn
        logic r_dp_have;
        logic r_dp_first;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_dp_have  <= 1'b0;
                r_dp_first <= 1'b0;
            end else if (!ena) begin
                r_dp_have <= 1'b0;
            end else if (w_strobe) begin
                r_dp_have <= ~r_dp_have;
                if (!r_dp_have) begin
                    r_dp_first <= w_sample;
                end
            end
        end

        // 10 -> 1, 01 -> 0: the emitted bit is the first half of an unequal pair.
        assign w_emit     = w_strobe && r_dp_have && (r_dp_first != w_sample);
        assign w_emit_bit = r_dp_first;
    end else begin : g_raw
        assign w_emit     = w_strobe;
        assign w_emit_bit = w_sample;
    end

    assign w_full      = (r_bcnt == BCNT_W'(WORD_W));
    assign w_hold_free = !r_out_valid || out_ready;
    assign w_xfer      = w_full && w_hold_free;
    // While a full word is moving out, the shreg may already take the first bit of the next word.
    assign w_shift     = w_emit && (!w_full || w_xfer);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shreg     <= '0;
            r_bcnt      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_shift) begin
                r_shreg <= {r_shreg[WORD_W-2:0], w_emit_bit};
            end
            if (w_xfer) begin
                r_bcnt <= w_shift ? BCNT_W'(1) : '0;
            end else if (w_shift) begin
                r_bcnt <= r_bcnt + BCNT_W'(1);
            end
            if (w_xfer) begin
                r_out_data  <= r_shreg;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign raw_bit   = r_raw_bit;
    assign stuck     = r_stuck;

endmodule

// File: tb/tb_ring_osc_trng.sv
// Directed bench: raw-packing and von Neumann instances share stimulus, DIV=2, WORD_W=8.
module tb_ring_osc_trng;
    logic       clk = 1'b0;
    logic       rst_n, ena, test_mode, test_bit, out_ready;
    logic [7:0] d0, d1;
    logic       v0, v1, raw0, raw1, stuck0, stuck1;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    ring_osc_trng #(
        .NUM_RINGS(4), .STAGES(5), .DIV(2), .WORD_W(8), .DEBIAS(0), .REP_LIMIT(16), .SIM_RINGS(1)
    ) u_raw (
        .clk(clk), .rst_n(rst_n), .ena(ena), .test_mode(test_mode), .test_bit(test_bit),
        .out_data(d0), .out_valid(v0), .out_ready(out_ready), .raw_bit(raw0), .stuck(stuck0)
    );

    ring_osc_trng #(
        .NUM_RINGS(4), .STAGES(5), .DIV(2), .WORD_W(8), .DEBIAS(1), .REP_LIMIT(16), .SIM_RINGS(1)
    ) u_vn (
        .clk(clk), .rst_n(rst_n), .ena(ena), .test_mode(test_mode), .test_bit(test_bit),
        .out_data(d1), .out_valid(v1), .out_ready(out_ready), .raw_bit(raw1), .stuck(stuck1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // After release the divider sits at 0, so each push_bit strobes on its second edge.
    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic push_bit(input logic b);
        test_bit = b;
        step();
        step();
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) push_bit(b[i]);
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (d0 !== 8'h00) begin n_err++; $display("FAIL reset out_data: got %h want 00", d0); end
        n_vec++; if (v0 !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b want 0", v0); end
        n_vec++; if (raw0 !== 1'b0) begin n_err++; $display("FAIL reset raw_bit: got %b want 0", raw0); end
        n_vec++; if (stuck0 !== 1'b0) begin n_err++; $display("FAIL reset stuck: got %b want 0", stuck0); end
        n_vec++; if (v1 !== 1'b0) begin n_err++; $display("FAIL reset vn out_valid: got %b want 0", v1); end
    endtask

    task automatic test_raw_word();
        do_reset();
        push_byte(8'hB2);
        n_vec++; if (raw0 !== 1'b0) begin n_err++; $display("FAIL raw_word raw_bit: got %b want 0", raw0); end
        n_vec++; if (v0 !== 1'b0) begin n_err++; $display("FAIL raw_word early valid: got %b want 0", v0); end
        step();
        n_vec++; if (v0 !== 1'b1) begin n_err++; $display("FAIL raw_word valid: got %b want 1", v0); end
        n_vec++; if (d0 !== 8'hB2) begin n_err++; $display("FAIL raw_word data: got %h want b2", d0); end
    endtask

    task automatic test_debias();
        // 10,01,11,10,00,10,01,10,11,01,01 -> 1,0,-,1,-,1,0,1,-,0,0 = 8'hB4
        logic [1:0] pairs [11] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b00, 2'b10,
                                   2'b01, 2'b10, 2'b11, 2'b01, 2'b01};
        do_reset();
        foreach (pairs[k]) begin
            push_bit(pairs[k][1]);
            push_bit(pairs[k][0]);
        end
        n_vec++; if (v1 !== 1'b0) begin n_err++; $display("FAIL debias early valid: got %b want 0", v1); end
        step();
        n_vec++; if (v1 !== 1'b1) begin n_err++; $display("FAIL debias valid: got %b want 1", v1); end
        n_vec++; if (d1 !== 8'hB4) begin n_err++; $display("FAIL debias data: got %h want b4", d1); end
    endtask

    task automatic test_debias_ena_clear();
        // A pending first half (1) must be discarded by ena=0; then eight 10 pairs give 8'hFF.
        do_reset();
        push_bit(1'b1);
        ena = 1'b0;
        step();
        step();
        ena = 1'b1;
        for (int k = 0; k < 8; k++) begin
            push_bit(1'b1);
            push_bit(1'b0);
        end
        step();
        n_vec++; if (v1 !== 1'b1) begin n_err++; $display("FAIL ena_clear valid: got %b want 1", v1); end
        n_vec++; if (d1 !== 8'hFF) begin n_err++; $display("FAIL ena_clear data: got %h want ff", d1); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b0;
        push_byte(8'h3C);
        push_byte(8'hA5);
        push_byte(8'hFF);
        n_vec++; if (v0 !== 1'b1) begin n_err++; $display("FAIL bp held valid: got %b want 1", v0); end
        n_vec++; if (d0 !== 8'h3C) begin n_err++; $display("FAIL bp held data: got %h want 3c", d0); end
        step();
        step();
        n_vec++; if (d0 !== 8'h3C) begin n_err++; $display("FAIL bp stable data: got %h want 3c", d0); end
        test_bit  = 1'b0;
        out_ready = 1'b1;
        step();
        n_vec++; if (v0 !== 1'b1) begin n_err++; $display("FAIL bp second valid: got %b want 1", v0); end
        n_vec++; if (d0 !== 8'hA5) begin n_err++; $display("FAIL bp second data: got %h want a5", d0); end
        step();
        n_vec++; if (v0 !== 1'b0) begin n_err++; $display("FAIL bp drained valid: got %b want 0", v0); end
        // Strobe above shifted a 0; seven more bits make 8'h55 with nothing of the dropped FF word.
        for (int k = 0; k < 7; k++) push_bit(k[0] ? 1'b0 : 1'b1);
        n_vec++; if (v0 !== 1'b0) begin n_err++; $display("FAIL bp no dup valid: got %b want 0", v0); end
        step();
        n_vec++; if (v0 !== 1'b1) begin n_err++; $display("FAIL bp next valid: got %b want 1", v0); end
        n_vec++; if (d0 !== 8'h55) begin n_err++; $display("FAIL bp next data: got %h want 55", d0); end
    endtask

    task automatic test_stuck();
        do_reset();
        for (int k = 0; k < 15; k++) push_bit(1'b1);
        n_vec++; if (stuck0 !== 1'b0) begin n_err++; $display("FAIL stuck at 15: got %b want 0", stuck0); end
        push_bit(1'b1);
        n_vec++; if (stuck0 !== 1'b1) begin n_err++; $display("FAIL stuck at 16: got %b want 1", stuck0); end
        n_vec++; if (stuck1 !== 1'b1) begin n_err++; $display("FAIL stuck vn at 16: got %b want 1", stuck1); end
        push_bit(1'b0);
        push_bit(1'b1);
        n_vec++; if (stuck0 !== 1'b1) begin n_err++; $display("FAIL stuck sticky: got %b want 1", stuck0); end
        do_reset();
        n_vec++; if (stuck0 !== 1'b0) begin n_err++; $display("FAIL stuck cleared: got %b want 0", stuck0); end
    endtask

    task automatic test_reset_mid_word();
        push_byte(8'h77);
        step();
        n_vec++; if (d0 !== 8'h77) begin n_err++; $display("FAIL midword first data: got %h want 77", d0); end
        step();
        for (int k = 0; k < 4; k++) push_bit(1'b1);
        do_reset();
        n_vec++; if (d0 !== 8'h00) begin n_err++; $display("FAIL midword reset data: got %h want 00", d0); end
        n_vec++; if (v0 !== 1'b0) begin n_err++; $display("FAIL midword reset valid: got %b want 0", v0); end
        push_byte(8'h5A);
        n_vec++; if (v0 !== 1'b0) begin n_err++; $display("FAIL midword early valid: got %b want 0", v0); end
        step();
        n_vec++; if (v0 !== 1'b1) begin n_err++; $display("FAIL midword valid: got %b want 1", v0); end
        n_vec++; if (d0 !== 8'h5A) begin n_err++; $display("FAIL midword data: got %h want 5a", d0); end
    endtask

    task automatic test_entropy_and_freeze();
        int   toggles;
        logic prev;
        logic held;
        test_mode = 1'b0;
        do_reset();
        toggles = 0;
        prev    = raw0;
        for (int k = 0; k < 1000; k++) begin
            push_bit(1'b0);
            if (raw0 !== prev) toggles++;
            prev = raw0;
        end
        n_vec++; if (toggles == 0) begin n_err++; $display("FAIL entropy toggles: got %0d want >0", toggles); end
        n_vec++; if (stuck0 !== 1'b0) begin n_err++; $display("FAIL entropy stuck: got %b want 0", stuck0); end
        test_mode = 1'b1;
        held      = raw0;
        test_bit  = ~held;
        ena       = 1'b0;
        repeat (11) step();
        n_vec++; if (raw0 !== held) begin n_err++; $display("FAIL freeze raw_bit: got %b want %b", raw0, held); end
        ena = 1'b1;
        step();
        n_vec++; if (raw0 !== held) begin n_err++; $display("FAIL freeze phase: got %b want %b", raw0, held); end
        step();
        n_vec++; if (raw0 !== ~held) begin n_err++; $display("FAIL resume sample: got %b want %b", raw0, ~held); end
    endtask

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b1;
        test_mode = 1'b1;
        test_bit  = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_raw_word();
        test_debias();
        test_debias_ena_clear();
        test_back_to_back();
        test_stuck();
        test_reset_mid_word();
        test_entropy_and_freeze();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
